// File: rtl/cook_timer_pkg.sv
// rtl/cook_timer_pkg.sv - shared types, constants and BCD helpers for the cook timer
package cook_timer_pkg;

  // Encoded controller state, also shown on the display
  typedef enum logic [2:0] {
    ST_IDLE  = 3'd0,
    ST_ARM   = 3'd1,
    ST_COOK  = 3'd2,
    ST_PAUSE = 3'd3,
    ST_DONE  = 3'd4
  } state_t;

  // Two packed BCD digits: [7:4] tens, [3:0] units
  typedef logic [7:0] bcd2_t;

  localparam bcd2_t      SEC_MAX_BCD = 8'h59;
  localparam logic [3:0] DIGIT_MAX   = 4'h9;

  // Force each BCD digit into 0..9
  function automatic bcd2_t clamp_bcd2(input bcd2_t v);
    logic [3:0] hi;
    logic [3:0] lo;
    hi = (v[7:4] > DIGIT_MAX) ? DIGIT_MAX : v[7:4];
    lo = (v[3:0] > DIGIT_MAX) ? DIGIT_MAX : v[3:0];
    return {hi, lo};
  endfunction

endpackage

// File: rtl/cook_timer_if.sv
// rtl/cook_timer_if.sv - keypad/door to controller bundle and controller outputs
interface cook_timer_if;
  import cook_timer_pkg::*;

  logic       load;
  bcd2_t      min_bcd;
  bcd2_t      sec_bcd;
  logic       start;
  logic       stop;
  logic       door_open;

  logic       mag_on;
  bcd2_t      min_out;
  bcd2_t      sec_out;
  logic       done;
  logic [2:0] state;

  // Keypad/door side: drives requests, observes status
  modport master (
    output load, min_bcd, sec_bcd, start, stop, door_open,
    input  mag_on, min_out, sec_out, done, state
  );

  // Controller side
  modport slave (
    input  load, min_bcd, sec_bcd, start, stop, door_open,
    output mag_on, min_out, sec_out, done, state
  );
endinterface

// File: rtl/mmss_bcd_down.sv
// rtl/mmss_bcd_down.sv - registered BCD mm:ss with clamped load and borrowing decrement
module mmss_bcd_down
  import cook_timer_pkg::*;
(
  input  logic  clock,
  input  logic  clear,
  input  logic  load,
  input  bcd2_t min_in,
  input  bcd2_t sec_in,
  input  logic  dec,
  input  logic  clr,
  output bcd2_t min_q,
  output bcd2_t sec_q,
  output logic  is_zero
);

  bcd2_t min_clamped;
  bcd2_t sec_clamped;
  bcd2_t min_dec;
  bcd2_t sec_dec;

  assign is_zero = (min_q == 8'h00) && (sec_q == 8'h00);

  // Preset sanitising: digits to 0..9, then seconds capped at 59 (digits are
  // valid BCD here, so a plain binary compare orders them correctly)
  always_comb begin
    min_clamped = clamp_bcd2(min_in);
    sec_clamped = clamp_bcd2(sec_in);
    if (sec_clamped > SEC_MAX_BCD) begin
      sec_clamped = SEC_MAX_BCD;
    end
  end

  // One-second BCD decrement with units->tens and seconds->minutes borrow
  always_comb begin
    sec_dec = sec_q;
    min_dec = min_q;
    if (sec_q[3:0] != 4'h0) begin
      sec_dec[3:0] = sec_q[3:0] - 4'h1;
    end else if (sec_q[7:4] != 4'h0) begin
      sec_dec = {sec_q[7:4] - 4'h1, DIGIT_MAX};
    end else begin
      sec_dec = SEC_MAX_BCD;
      if (min_q[3:0] != 4'h0) begin
        min_dec[3:0] = min_q[3:0] - 4'h1;
      end else begin
        min_dec = {min_q[7:4] - 4'h1, DIGIT_MAX};
      end
    end
  end

  // Time register: clear/cancel, then load, then decrement (held at 00:00)
  always_ff @(posedge clock) begin
    if (clear || clr) begin
      min_q <= 8'h00;
      sec_q <= 8'h00;
    end else if (load) begin
      min_q <= min_clamped;
      sec_q <= sec_clamped;
    end else if (dec && !is_zero) begin
      min_q <= min_dec;
      sec_q <= sec_dec;
    end
  end

endmodule

// File: rtl/cook_timer_ctrl.sv
// rtl/cook_timer_ctrl.sv - microwave cook cycle sequencer: arm delay, 1 s countdown, pause/done
module cook_timer_ctrl
  import cook_timer_pkg::*;
#(
  parameter int TICK_DIV    = 100,
  parameter int START_DELAY = 4
) (
  input  logic         clock,
  input  logic         clear,
  cook_timer_if.slave  bus
);

  localparam int PW = $clog2(TICK_DIV);
  localparam int AW = $clog2(START_DELAY + 1);
  localparam logic [PW-1:0] PRESC_LAST = PW'(TICK_DIV - 1);
  localparam logic [AW-1:0] ARM_LAST   = AW'(START_DELAY - 1);

  state_t        state_q;
  logic          mag_q;
  logic          done_q;
  logic [PW-1:0] presc_q;
  logic [AW-1:0] arm_q;

  bcd2_t tm_min;
  bcd2_t tm_sec;
  logic  tm_zero;
  logic  tm_one;

  // Per-cycle decisions after applying door > stop > start > load priority
  logic go_pause;
  logic arm_done;
  logic tick;
  logic do_start;
  logic do_cancel;
  logic do_load;
  logic do_exit;

  assign tm_one = (tm_min == 8'h00) && (tm_sec == 8'h01);

  // Decode requests against the current state; door only matters where it
  // can pause or block, and is ignored entirely once cooking is done
  always_comb begin
    go_pause  = 1'b0;
    arm_done  = 1'b0;
    tick      = 1'b0;
    do_start  = 1'b0;
    do_cancel = 1'b0;
    do_load   = 1'b0;
    do_exit   = 1'b0;
    unique case (state_q)
      ST_IDLE: begin
        if (!bus.door_open && !bus.stop) begin
          if (bus.start) begin
            do_start = !tm_zero;
          end else if (bus.load) begin
            do_load = 1'b1;
          end
        end
      end
      ST_ARM: begin
        if (bus.door_open || bus.stop) begin
          go_pause = 1'b1;
        end else if (arm_q == ARM_LAST) begin
          arm_done = 1'b1;
        end
      end
      ST_COOK: begin
        if (bus.door_open || bus.stop) begin
          go_pause = 1'b1;
        end else if (presc_q == PRESC_LAST) begin
          tick = 1'b1;
        end
      end
      ST_PAUSE: begin
        if (!bus.door_open) begin
          if (bus.stop) begin
            do_cancel = 1'b1;
          end else if (bus.start) begin
            do_start = 1'b1;
          end else if (bus.load) begin
            do_load = 1'b1;
          end
        end
      end
      ST_DONE: begin
        if (bus.start || bus.stop) begin
          do_exit = 1'b1;
        end else if (bus.load) begin
          do_load = 1'b1;
        end
      end
      default: begin
      end
    endcase
  end

  mmss_bcd_down u_mmss (
    .clock   (clock),
    .clear   (clear),
    .load    (do_load),
    .min_in  (bus.min_bcd),
    .sec_in  (bus.sec_bcd),
    .dec     (tick),
    .clr     (do_cancel),
    .min_q   (tm_min),
    .sec_q   (tm_sec),
    .is_zero (tm_zero)
  );

  // Controller FSM with registered magnetron/done outputs and its counters
  always_ff @(posedge clock) begin
    if (clear) begin
      state_q <= ST_IDLE;
      mag_q   <= 1'b0;
      done_q  <= 1'b0;
      presc_q <= '0;
      arm_q   <= '0;
    end else begin
      unique case (state_q)
        ST_IDLE: begin
          if (do_start) begin
            state_q <= ST_ARM;
            arm_q   <= '0;
          end
        end
        ST_ARM: begin
          if (go_pause) begin
            state_q <= ST_PAUSE;
            arm_q   <= '0;
          end else if (arm_done) begin
            state_q <= ST_COOK;
            mag_q   <= 1'b1;
            presc_q <= '0;
            arm_q   <= '0;
          end else begin
            arm_q <= arm_q + 1'b1;
          end
        end
        ST_COOK: begin
          if (go_pause) begin
            state_q <= ST_PAUSE;
            mag_q   <= 1'b0;
            presc_q <= '0;
          end else if (tick) begin
            presc_q <= '0;
            if (tm_one) begin
              state_q <= ST_DONE;
              mag_q   <= 1'b0;
              done_q  <= 1'b1;
            end
          end else begin
            presc_q <= presc_q + 1'b1;
          end
        end
        ST_PAUSE: begin
          if (do_start) begin
            state_q <= ST_ARM;
            arm_q   <= '0;
          end else if (do_cancel || do_load) begin
            state_q <= ST_IDLE;
          end
        end
        ST_DONE: begin
          if (do_exit || do_load) begin
            state_q <= ST_IDLE;
            done_q  <= 1'b0;
          end
        end
        default: begin
          state_q <= ST_IDLE;
          mag_q   <= 1'b0;
          done_q  <= 1'b0;
        end
      endcase
    end
  end

  assign bus.state   = state_q;
  assign bus.mag_on  = mag_q;
  assign bus.done    = done_q;
  assign bus.min_out = tm_min;
  assign bus.sec_out = tm_sec;

endmodule
